// File: rtl/muldiv_unit.sv
// Signed 32-bit multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Results land in HI/LO N cycles after accept; starts are only accepted while idle.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mult_E,
    input  logic        div_E,
    input  logic        mfhi_E,
    input  logic        mflo_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        busy,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_wr;

    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    assign product = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});

    // Divide on magnitudes so the 0x80000000 / -1 case wraps to 0x80000000 with no special path.
    assign a_neg    = rs_E[31];
    assign b_neg    = rt_E[31];
    assign a_mag    = a_neg ? (~rs_E + 32'd1) : rs_E;
    assign b_mag    = b_neg ? (~rt_E + 32'd1) : rt_E;
    assign div_zero = (rt_E == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign uquot    = a_mag / b_safe;
    assign urem     = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    assign rem      = a_neg ? (~urem + 32'd1) : urem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && mult_E) begin
                        p_hi  <= product[63:32];
                        p_lo  <= product[31:0];
                        p_wr  <= 1'b1;
                        cnt   <= 4'(MULT_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else if (start && div_E) begin
                        p_hi  <= rem;
                        p_lo  <= quot;
                        p_wr  <= !div_zero;
                        cnt   <= 4'(DIV_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        if (p_wr) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                        cnt   <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hilo_out = 32'd0;
        if (mfhi_E)
            hilo_out = hi;
        else if (mflo_E)
            hilo_out = lo;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mult_E = 1'b0;
    logic        div_E = 1'b0;
    logic        mfhi_E = 1'b0;
    logic        mflo_E = 1'b0;
    logic [31:0] rs_E = 32'd0;
    logic [31:0] rt_E = 32'd0;
    logic        busy;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit allow_busy_start = 1'b0;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mult_E(mult_E), .div_E(div_E),
        .mfhi_E(mfhi_E), .mflo_E(mflo_E), .rs_E(rs_E), .rt_E(rt_E),
        .busy(busy), .hilo_out(hilo_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // A start while busy is a hazard-unit protocol violation unless deliberately injected.
    always @(posedge clk) begin
        if (reset_n && busy && start)
            assert (allow_busy_start) else $error("start issued while busy");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the instruction should do architecturally and for how long.
    task automatic model(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         output int n, output bit wr, output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = 0; wr = 0; h = 0; l = 0;
        if (m) begin
            n = MC; wr = 1;
            p = sa * sb;
            h = p[63:32]; l = p[31:0];
        end else if (d) begin
            n = DC;
            if (sb != 0) begin
                wr = 1;
                q = sa / sb;
                r = sa - q * sb;
                h = r[31:0]; l = q[31:0];
            end
        end
    endtask

    task automatic chk_hilo(string tag);
        logic [31:0] e;
        for (int s = 0; s < 4; s++) begin
            mfhi_E = s[1]; mflo_E = s[0];
            #1;
            e = s[1] ? m_hi : (s[0] ? m_lo : 32'd0);
            check({tag, "_hilo"}, {32'd0, hilo_out}, {32'd0, e});
        end
        mfhi_E = 0; mflo_E = 0;
    endtask

    // Called just after a negedge with the unit idle; returns at the negedge where busy is low.
    task automatic run_op(string tag, bit m, bit d, logic [31:0] a, logic [31:0] b, bit inj);
        int n_exp, n;
        bit wr;
        logic [31:0] h, l;
        model(m, d, a, b, n_exp, wr, h, l);
        start = 1; mult_E = m; div_E = d; rs_E = a; rt_E = b;
        @(negedge clk);
        start = 0; mult_E = 0; div_E = 0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (inj && n == 2) begin
                allow_busy_start = 1; start = 1; mult_E = 1; rs_E = 32'd5; rt_E = 32'd5;
            end else begin
                allow_busy_start = 0; start = 0; mult_E = 0;
            end
            // Mid-run reads still show the pre-operation values.
            if (n == 1) check({tag, "_hi_midrun"}, {32'd0, hi}, {32'd0, m_hi});
            @(negedge clk);
        end
        start = 0; mult_E = 0; allow_busy_start = 0;
        check({tag, "_busy_len"}, 64'(n), 64'(n_exp));
        if (wr) begin
            m_hi = h; m_lo = l;
        end
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        logic [31:0] a, b;
        int r;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        chk_hilo("rst");

        run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7_m3_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mul_7_m3_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        chk_hilo("mul_7_m3");

        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_m7_2_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        run_op("b2b_mul", 1, 0, 32'd9, 32'd11, 0);

        run_op("load", 0, 1, 32'h451, 32'h20, 0);
        check("load_hi_const", {32'd0, hi}, 64'h11);
        check("load_lo_const", {32'd0, lo}, 64'h22);
        run_op("divzero", 0, 1, 32'd1234, 32'd0, 0);
        check("divzero_hi_const", {32'd0, hi}, 64'h11);
        check("divzero_lo_const", {32'd0, lo}, 64'h22);
        run_op("divovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("divovf_lo_const", {32'd0, lo}, 64'h8000_0000);
        check("divovf_hi_const", {32'd0, hi}, 64'h0);

        run_op("ignore_none", 0, 0, 32'd3, 32'd4, 0);
        run_op("both_set", 1, 1, 32'd6, 32'd3, 0);
        run_op("midrun_start", 1, 0, 32'd3, 32'd4, 1);
        check("midrun_lo_const", {32'd0, lo}, 64'd12);
        check("midrun_hi_const", {32'd0, hi}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: a = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op("rand", (r == 1) || (r >= 2 && r <= 5), (r == 1) || (r >= 6),
                   a, b, 0);
            if (i % 8 == 0) chk_hilo("rand");
        end

        // Reset in the middle of a multiply: no commit may follow.
        start = 1; mult_E = 1; rs_E = 32'd3; rt_E = 32'd4;
        @(negedge clk);
        start = 0; mult_E = 0;
        @(negedge clk);
        reset_n = 0;
        #1;
        m_hi = 0; m_lo = 0;
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_hi", {32'd0, hi}, 64'd0);
        check("rstmid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1;
        repeat (8) @(negedge clk);
        check("rstmid_after_busy", {63'd0, busy}, 64'd0);
        check("rstmid_after_lo", {32'd0, lo}, 64'd0);
        chk_hilo("rstmid");
        run_op("post_rst_mul", 1, 0, 32'hFFFF_0000, 32'h0001_0001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
